// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one data-memory load/store at a time for the multi-cycle core.
// Checks alignment, drives the memory port with byte enables, waits for mem_ready and, for
// loads, hands the sign/zero-extended lane to the MDR.
// Optional feature macro: MEM_TIMEOUT_EN -- abort an ACCESS that sees no mem_ready within
// TIMEOUT cycles.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TO_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_re,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        load_mdr,
    output logic [31:0] mdr_data_in
);

    typedef enum logic [2:0] {StIdle, StAccess, StLoad, StDone, StErr} state_e;

    state_e      state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mdr_q;
    logic        bad_req;
    logic        timed_out;
    logic [31:0] load_ext;

    // Illegal size or misaligned half/word request on the live inputs.
    always_comb begin
        bad_req = 1'b0;
        unique case (funct3[1:0])
            2'b01:   bad_req = addr[0];
            2'b10:   bad_req = (addr[1:0] != 2'b00);
            2'b11:   bad_req = 1'b1;
            default: bad_req = 1'b0;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [TO_W-1:0] to_q;

    // Wait counter: cleared before ACCESS, counts ACCESS cycles without mem_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_q <= '0;
        end else if (state_q == StIdle) begin
            to_q <= '0;
        end else if (state_q == StAccess && !mem_ready) begin
            to_q <= to_q + 1'b1;
        end
    end

    // Limit reached on this cycle's increment; mem_ready on the same cycle wins.
    assign timed_out = (to_q == TO_W'(TIMEOUT - 1)) && !mem_ready;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT, TO_W};
    assign timed_out  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = bad_req ? StErr : StAccess;
                end
            end
            StAccess: begin
                if (mem_ready) begin
                    state_d = we_q ? StDone : StLoad;
                end else if (timed_out) begin
                    state_d = StErr;
                end
            end
            StLoad, StDone, StErr: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane extraction for loads from the returned word.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b   = mem_rdata[8*addr_q[1:0] +: 8];
        lane_h   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = mem_rdata;
        unique case (funct3_q[1:0])
            2'b00:   load_ext = {{24{lane_b[7] & ~funct3_q[2]}}, lane_b};
            2'b01:   load_ext = {{16{lane_h[15] & ~funct3_q[2]}}, lane_h};
            default: load_ext = mem_rdata;
        endcase
    end

    // Request capture in IDLE and MDR data latch on load completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            mdr_q    <= 32'h0;
        end else begin
            if (state_q == StIdle && req) begin
                we_q     <= we;
                funct3_q <= funct3;
                addr_q   <= addr;
                wdata_q  <= wdata;
            end
            if (state_q == StAccess && mem_ready && !we_q) begin
                mdr_q <= load_ext;
            end
        end
    end

    // Outputs decoded from state and captured request.
    always_comb begin
        busy        = (state_q != StIdle);
        done        = 1'b0;
        err         = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_be      = 4'b0000;
        load_mdr    = 1'b0;
        mem_addr    = {addr_q[31:2], 2'b00};
        mdr_data_in = mdr_q;
        unique case (funct3_q[1:0])
            2'b00:   mem_wdata = {4{wdata_q[7:0]}};
            2'b01:   mem_wdata = {2{wdata_q[15:0]}};
            default: mem_wdata = wdata_q;
        endcase
        unique case (state_q)
            StAccess: begin
                mem_re = ~we_q;
                mem_we = we_q;
                unique case (funct3_q[1:0])
                    2'b00:   mem_be = 4'b0001 << addr_q[1:0];
                    2'b01:   mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
                    default: mem_be = 4'b1111;
                endcase
            end
            StLoad: begin
                done     = 1'b1;
                load_mdr = 1'b1;
            end
            StDone: done = 1'b1;
            StErr: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
